// File: rtl/gtp_frame_rx.sv
// Per-lane frame receiver behind the GTP RX wrapper: link tracking on K28.5 idles,
// frame delimiting, length/checksum validation and saturating error counters.
module gtp_frame_rx #(
   parameter int         LINK_CNT = 16,
   parameter int         MAX_LEN  = 1024,
   parameter logic [7:0] COMMA    = 8'hBC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] rx_data,
   input  logic        rx_charisk,
   input  logic        cnt_clr,
   output logic        link_up,
   output logic [15:0] dout,
   output logic        dout_vld,
   output logic        dout_sof,
   output logic        dout_eof,
   output logic        frame_done,
   output logic        frame_err,
   output logic [15:0] err_frames,
   output logic [15:0] err_link
);

   typedef enum logic [1:0] {ST_DOWN, ST_IDLE, ST_PAYLOAD, ST_CSUM} state_t;

   localparam logic [7:0]  LINK_CNT_M1 = 8'(LINK_CNT - 1);
   localparam logic [11:0] MAX_LEN_W   = 12'(MAX_LEN);

   state_t      state_q, state_d;
   logic [7:0]  idle_cnt_q, idle_cnt_d;
   logic [11:0] rem_q, rem_d;
   logic [15:0] sum_q, sum_d;
   logic        link_up_q, link_up_d;
   logic [15:0] dout_q, dout_d;
   logic        dout_vld_q, dout_vld_d;
   logic        dout_sof_q, dout_sof_d;
   logic        dout_eof_q, dout_eof_d;
   logic        frame_done_q, frame_done_d;
   logic        frame_err_q, frame_err_d;
   logic [15:0] err_frames_q, err_frames_d;
   logic [15:0] err_link_q, err_link_d;

   logic        is_idle, is_badk, is_data;
   logic [11:0] hdr_len;
   logic        inc_frame, inc_link, abort;

   assign is_idle = rx_charisk && (rx_data[7:0] == COMMA);
   assign is_badk = rx_charisk && (rx_data[7:0] != COMMA);
   assign is_data = !rx_charisk;
   assign hdr_len = rx_data[11:0];

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
      state_d      = state_q;
      idle_cnt_d   = idle_cnt_q;
      rem_d        = rem_q;
      sum_d        = sum_q;
      dout_d       = dout_q;
      dout_vld_d   = 1'b0;
      dout_sof_d   = 1'b0;
      dout_eof_d   = 1'b0;
      frame_done_d = 1'b0;
      frame_err_d  = 1'b0;
      inc_frame    = 1'b0;
      inc_link     = 1'b0;
      abort        = 1'b0;

      case (state_q)
         ST_DOWN: begin
            if (!is_idle) begin
               idle_cnt_d = '0;
            end else if (idle_cnt_q == LINK_CNT_M1) begin
               idle_cnt_d = '0;
               state_d    = ST_IDLE;
            end else begin
               idle_cnt_d = idle_cnt_q + 8'd1;
            end
         end
         ST_IDLE: begin
            if (is_badk) begin
               state_d  = ST_DOWN;
               inc_link = 1'b1;
            end else if (is_data) begin
               if (hdr_len == '0 || hdr_len > MAX_LEN_W) begin
                  frame_done_d = 1'b1;
                  frame_err_d  = 1'b1;
                  inc_frame    = 1'b1;
               end else begin
                  dout_d     = rx_data;
                  dout_vld_d = 1'b1;
                  dout_sof_d = 1'b1;
                  rem_d      = hdr_len;
                  sum_d      = rx_data;
                  state_d    = ST_PAYLOAD;
               end
            end
         end
         ST_PAYLOAD: begin
            if (is_data) begin
               dout_d     = rx_data;
               dout_vld_d = 1'b1;
               sum_d      = sum_q + rx_data;
               rem_d      = rem_q - 12'd1;
               if (rem_q == 12'd1) begin
                  dout_eof_d = 1'b1;
                  state_d    = ST_CSUM;
               end
            end else begin
               abort = 1'b1;
            end
         end
         ST_CSUM: begin
            if (is_data) begin
               frame_done_d = 1'b1;
               frame_err_d  = (rx_data != sum_q);
               inc_frame    = (rx_data != sum_q);
               state_d      = ST_IDLE;
            end else begin
               abort = 1'b1;
            end
         end
         default: state_d = ST_DOWN;
      endcase

      // Any K-word inside a frame kills it; a non-comma K-word also drops the link.
      if (abort) begin
         frame_done_d = 1'b1;
         frame_err_d  = 1'b1;
         inc_frame    = 1'b1;
         if (is_badk) begin
            state_d  = ST_DOWN;
            inc_link = 1'b1;
         end else begin
            state_d = ST_IDLE;
         end
      end

      link_up_d = (state_d != ST_DOWN);

      // Clear wins over a same-cycle increment; increments stick at all-ones.
      if (cnt_clr)                               err_frames_d = '0;
      else if (inc_frame && err_frames_q != '1)  err_frames_d = err_frames_q + 16'd1;
      else                                       err_frames_d = err_frames_q;

      if (cnt_clr)                               err_link_d = '0;
      else if (inc_link && err_link_q != '1)     err_link_d = err_link_q + 16'd1;
      else                                       err_link_d = err_link_q;
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_DOWN;
         idle_cnt_q   <= '0;
         rem_q        <= '0;
         sum_q        <= '0;
         link_up_q    <= 1'b0;
         dout_q       <= '0;
         dout_vld_q   <= 1'b0;
         dout_sof_q   <= 1'b0;
         dout_eof_q   <= 1'b0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
         err_frames_q <= '0;
         err_link_q   <= '0;
      end else begin
         state_q      <= state_d;
         idle_cnt_q   <= idle_cnt_d;
         rem_q        <= rem_d;
         sum_q        <= sum_d;
         link_up_q    <= link_up_d;
         dout_q       <= dout_d;
         dout_vld_q   <= dout_vld_d;
         dout_sof_q   <= dout_sof_d;
         dout_eof_q   <= dout_eof_d;
         frame_done_q <= frame_done_d;
         frame_err_q  <= frame_err_d;
         err_frames_q <= err_frames_d;
         err_link_q   <= err_link_d;
      end
   end

   assign link_up    = link_up_q;
   assign dout       = dout_q;
   assign dout_vld   = dout_vld_q;
   assign dout_sof   = dout_sof_q;
   assign dout_eof   = dout_eof_q;
   assign frame_done = frame_done_q;
   assign frame_err  = frame_err_q;
   assign err_frames = err_frames_q;
   assign err_link   = err_link_q;

endmodule

// File: tb/tb_gtp_frame_rx.sv
// Scoreboard bench for gtp_frame_rx: expected words/results are queued as stimulus
// is driven and retired by a negedge monitor as the receiver produces them.
module tb_gtp_frame_rx;

   localparam int LINK_CNT = 16;
   localparam int MAX_LEN  = 1024;

   typedef struct packed {
      logic        sof;
      logic        eof;
      logic [15:0] data;
   } dout_exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] rx_data = 16'h00BC;
   logic        rx_charisk = 1'b1;
   logic        cnt_clr = 1'b0;
   logic        link_up;
   logic [15:0] dout;
   logic        dout_vld, dout_sof, dout_eof;
   logic        frame_done, frame_err;
   logic [15:0] err_frames, err_link;

   int          n_checks = 0;
   int          n_errors = 0;
   dout_exp_t   exp_dout[$];
   logic        exp_res[$];

   gtp_frame_rx #(.LINK_CNT(LINK_CNT), .MAX_LEN(MAX_LEN), .COMMA(8'hBC)) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_data    (rx_data),
      .rx_charisk (rx_charisk),
      .cnt_clr    (cnt_clr),
      .link_up    (link_up),
      .dout       (dout),
      .dout_vld   (dout_vld),
      .dout_sof   (dout_sof),
      .dout_eof   (dout_eof),
      .frame_done (frame_done),
      .frame_err  (frame_err),
      .err_frames (err_frames),
      .err_link   (err_link)
   );

   always #4 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic drive(input logic k, input logic [15:0] d);
      rx_charisk = k;
      rx_data    = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idles(input int n);
      for (int i = 0; i < n; i++) drive(1'b1, 16'h00BC);
   endtask

   task automatic send_word(input logic [15:0] d, input logic sof, input logic eof);
      exp_dout.push_back('{sof: sof, eof: eof, data: d});
      drive(1'b0, d);
   endtask

   // Full frame with n payload words (n <= 3); expected frame_err from our own sum.
   task automatic send_frame(input logic [15:0] hdr, input int n,
                             input logic [15:0] p0, input logic [15:0] p1,
                             input logic [15:0] p2, input logic [15:0] csum);
      logic [15:0] pl[3];
      logic [15:0] sum;
      pl[0] = p0; pl[1] = p1; pl[2] = p2;
      sum = hdr;
      send_word(hdr, 1'b1, 1'b0);
      for (int i = 0; i < n; i++) begin
         sum = sum + pl[i];
         send_word(pl[i], 1'b0, i == n - 1);
      end
      exp_res.push_back(csum != sum);
      drive(1'b0, csum);
   endtask

   task automatic bad_header(input logic [15:0] hdr);
      exp_res.push_back(1'b1);
      drive(1'b0, hdr);
   endtask

   task automatic bring_up(input string tag);
      idles(LINK_CNT - 1);
      check({tag, "_before"}, 32'(link_up), 0);
      idles(1);
      check({tag, "_after"}, 32'(link_up), 1);
   endtask

   always @(negedge clk) begin
      if (dout_vld) begin
         check("vld_expected", 32'(exp_dout.size() != 0), 1);
         if (exp_dout.size() != 0) begin
            dout_exp_t e;
            e = exp_dout.pop_front();
            check("dout", 32'(dout), 32'(e.data));
            check("dout_sof", 32'(dout_sof), 32'(e.sof));
            check("dout_eof", 32'(dout_eof), 32'(e.eof));
         end
      end
      if (frame_done) begin
         check("done_expected", 32'(exp_res.size() != 0), 1);
         if (exp_res.size() != 0) begin
            logic r;
            r = exp_res.pop_front();
            check("frame_err", 32'(frame_err), 32'(r));
         end
      end
   end

   initial begin
      idles(3);
      check("rst_link_up", 32'(link_up), 0);
      check("rst_dout", 32'(dout), 0);
      check("rst_vld", 32'({dout_vld, dout_sof, dout_eof, frame_done, frame_err}), 0);
      check("rst_err_frames", 32'(err_frames), 0);
      check("rst_err_link", 32'(err_link), 0);
      reset = 1'b0;

      // A data word in the middle of the idle run restarts the count.
      idles(LINK_CNT - 1);
      check("bringup_partial", 32'(link_up), 0);
      drive(1'b0, 16'h1234);
      check("bringup_data", 32'(link_up), 0);
      bring_up("bringup");

      send_frame(16'h0003, 3, 16'h1111, 16'h2222, 16'h3333, 16'h6669);
      idles(1);
      check("good_err_frames", 32'(err_frames), 0);

      send_frame(16'h0003, 3, 16'h1111, 16'h2222, 16'h3333, 16'h6668);
      idles(1);
      check("csum_err_frames", 32'(err_frames), 1);

      bad_header(16'h0000);
      idles(1);
      check("len0_err_frames", 32'(err_frames), 2);

      bad_header(16'(MAX_LEN + 1));
      idles(1);
      check("lenmax_err_frames", 32'(err_frames), 3);

      // Truncation by an idle after one payload word.
      send_word(16'h0003, 1'b1, 1'b0);
      send_word(16'h1111, 1'b0, 1'b0);
      exp_res.push_back(1'b1);
      idles(1);
      check("trunc_link_up", 32'(link_up), 1);
      check("trunc_err_frames", 32'(err_frames), 4);

      // Back-to-back, second frame's checksum wraps past 16 bits.
      send_frame(16'h0003, 3, 16'h1111, 16'h2222, 16'h3333, 16'h6669);
      send_frame(16'h0002, 2, 16'hFFFF, 16'h0002, 16'h0000, 16'h0003);
      idles(1);
      check("b2b_err_frames", 32'(err_frames), 4);

      // K28.0 mid-frame drops the link.
      send_word(16'h0003, 1'b1, 1'b0);
      send_word(16'h1111, 1'b0, 1'b0);
      exp_res.push_back(1'b1);
      drive(1'b1, 16'h001C);
      check("badk_link_up", 32'(link_up), 0);
      check("badk_err_link", 32'(err_link), 1);
      check("badk_err_frames", 32'(err_frames), 5);
      bring_up("relink");

      force dut.err_frames_q = 16'hFFFF;
      #1;
      release dut.err_frames_q;
      bad_header(16'h0000);
      idles(1);
      check("sat_err_frames", 32'(err_frames), 32'hFFFF);

      cnt_clr = 1'b1;
      bad_header(16'h0000);
      cnt_clr = 1'b0;
      check("clr_err_frames", 32'(err_frames), 0);
      check("clr_err_link", 32'(err_link), 0);
      idles(1);

      // Reset in the middle of a payload: no done, outputs cleared.
      send_word(16'h0003, 1'b1, 1'b0);
      send_word(16'h1111, 1'b0, 1'b0);
      reset = 1'b1;
      idles(1);
      reset = 1'b0;
      check("midrst_link_up", 32'(link_up), 0);
      check("midrst_dout", 32'(dout), 0);
      check("midrst_flags", 32'({dout_vld, dout_sof, dout_eof, frame_done, frame_err}), 0);
      bring_up("post_reset");

      send_frame(16'h0001, 1, 16'hABCD, 16'h0000, 16'h0000, 16'hABCE);
      idles(3);
      check("dout_queue_empty", 32'(exp_dout.size()), 0);
      check("res_queue_empty", 32'(exp_res.size()), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
